drp_reconf_master: RTL and testbench
====================================

# drp_reconf_master

DRP initiator that reprograms one MMCM/PLL output divider through the dynamic reconfiguration port. It sits between user control logic and the `dyn_reconf` DRP responder.

On a single START it performs read-modify-write cycles on ClkReg1 and ClkReg2 of the selected output, holding PLL_RST asserted for the whole sequence. Reserved and fractional register bits are preserved.

## Interface
- TIMEOUT_CYCLES, 64: DRP wait-state limit, in DCLK cycles, before an access is aborted (used only with the timeout feature).

- DCLK  in  1  DRP clock; the only clock.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  request strobe; sampled only in IDLE.
- SEL  in  3  target output: 0–6 = CLKOUT0–6, 7 = CLKFBOUT.
- HIGH_TIME  in  6  ClkReg1[11:6].
- LOW_TIME  in  6  ClkReg1[5:0].
- PHASE_MUX  in  3  ClkReg1[15:13].
- DELAY_TIME  in  6  ClkReg2[5:0].
- NO_COUNT  in  1  ClkReg2[6].
- EDGE  in  1  ClkReg2[7].
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle completion pulse.
- ERROR  out  1  sticky timeout flag; cleared by the next accepted START or by RST.
- PLL_RST  out  1  PLL reset, held high during reconfiguration.
- DADDR  out  7  DRP address.
- DEN  out  1  DRP enable.
- DWE  out  1  DRP write enable.
- DI  out  16  DRP write data.
- DO  in  16  DRP read data.
- DRDY  in  1  DRP ready.

## Operation
- Address pairs (ClkReg1/ClkReg2) by SEL:
  - CLKOUT5 0x06/0x07
  - CLKOUT0 0x08/0x09
  - CLKOUT1 0x0A/0x0B
  - CLKOUT2 0x0C/0x0D
  - CLKOUT3 0x0E/0x0F
  - CLKOUT4 0x10/0x11
  - CLKOUT6 0x12/0x13
  - CLKFBOUT 0x14/0x15
- Capture: all request inputs are registered on the accepted START edge. Later input changes have no effect.
- State sequence: IDLE → RD1 → WAIT_RD1 → WR1 → WAIT_WR1 → RD2 → WAIT_RD2 → WR2 → WAIT_WR2 → FIN → IDLE.
- Issue states (RD*, WR*) are one cycle long:
  - DEN=1 for exactly that cycle.
  - DWE=1 only in WR*.
  - DADDR is valid in the issue cycle and held through the following wait state.
- Wait states advance on the cycle DRDY=1 is sampled. A read wait latches DO into the read-back register. DRDY outside wait states is ignored.
- ClkReg1 write data: (DO & 16'h1000) | {PHASE_MUX, 1'b0, HIGH_TIME, LOW_TIME}.
- ClkReg2 write data: (DO & 16'hFF00) | {EDGE, NO_COUNT, DELAY_TIME}. This preserves reserved, FRAC, FRAC_EN, FRAC_WF_R and MX.
- FIN: DONE=1 and PLL_RST=0 in the same cycle; BUSY drops that cycle.
- START while BUSY=1 is ignored; no queueing.
- Reset values: all outputs 0, including PLL_RST, DADDR and DI; state IDLE.
- RST mid-sequence: abort on the next edge with no further DEN, and PLL_RST drops to 0.

## Timing
- START at edge n:
  - BUSY=1, PLL_RST=1 and DEN=1 (RD1) are all registered at edge n+1.
  - Each access takes 1 issue cycle plus L wait cycles, where L is the responder latency (DRDY high L cycles after the DEN cycle).
  - Total START→DONE latency is 4·(L+1)+1 cycles.
- The cycle after a wait state exits is the next issue cycle; there is no idle gap.
- DEN is never asserted while an access is outstanding.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- DRP_TIMEOUT_EN defined:
  - A wait counter clears on each DEN and increments in wait states.
  - If it reaches TIMEOUT_CYCLES without DRDY, the block goes to FIN with ERROR=1 and DONE pulses.
  - PLL_RST is released and no further accesses are issued.
- DRP_TIMEOUT_EN undefined:
  - Wait states wait indefinitely.
  - ERROR is tied 0 and there is no counter logic.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package `drp_pkg`:
  - ClkReg address constants per SEL.
  - Field bit positions.
  - Preserve masks 16'h1000 / 16'hFF00.
  - State enum.
- Sub-module `drp_access`: one DRP transaction (issue, wait for DRDY, optional timeout), returning read data plus done/error strobes. The FSM in drp_reconf_master sequences four drp_access calls.

## Test plan
- SEL=0, HIGH=6, LOW=3, PHASE_MUX=3, DELAY=3, NO_COUNT=1, EDGE=0; responder holds 0x1000 at 0x08 and 0x8000 at 0x09, L=2 → writes 0x7183 to 0x08 and 0x8043 to 0x09; DONE 13 cycles after START; PLL_RST high throughout.
- Same request with SEL=5 on a zeroed responder → writes 0x6183 to 0x06 and 0x0043 to 0x07. SEL=7 → addresses 0x14/0x15.
- START pulsed again while BUSY, with different SEL → ignored; exactly four DEN pulses, one DONE.
- DRP_TIMEOUT_EN, responder never raises DRDY → ERROR=1 and DONE 64 cycles after the RD1 DEN; PLL_RST=0. The next START clears ERROR.
- RST asserted during WAIT_WR1 → next cycle all outputs 0, no further DEN; a fresh START completes normally.
- DRDY pulsed spuriously in IDLE and in an issue cycle → no state change, no DO capture.

Source files
------------

// File: rtl/drp_pkg.sv
// drp_pkg: shared definitions for the DRP output-divider reconfiguration slice.
//   - drp_state_e   : sequencing states of drp_reconf_master
//   - ClkReg1/ClkReg2 DRP addresses per output select (0-6 = CLKOUT0-6, 7 = CLKFBOUT)
//   - ClkReg field bit positions and read-modify-write preserve masks
package drp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD1,
    S_WAIT_RD1,
    S_WR1,
    S_WAIT_WR1,
    S_RD2,
    S_WAIT_RD2,
    S_WR2,
    S_WAIT_WR2,
    S_FIN
  } drp_state_e;

  // Bits kept from the read-back value: ClkReg1 keeps its reserved bit 12,
  // ClkReg2 keeps reserved/FRAC/FRAC_EN/FRAC_WF_R/MX in the upper byte.
  localparam logic [15:0] CLKREG1_KEEP = 16'h1000;
  localparam logic [15:0] CLKREG2_KEEP = 16'hFF00;

  localparam int unsigned PHASE_MUX_LSB  = 13;
  localparam int unsigned HIGH_TIME_LSB  = 6;
  localparam int unsigned LOW_TIME_LSB   = 0;
  localparam int unsigned DELAY_TIME_LSB = 0;
  localparam int unsigned NO_COUNT_BIT   = 6;
  localparam int unsigned EDGE_BIT       = 7;

  localparam logic [6:0] ADDR_CLKOUT5  = 7'h06;
  localparam logic [6:0] ADDR_CLKOUT0  = 7'h08;
  localparam logic [6:0] ADDR_CLKOUT1  = 7'h0A;
  localparam logic [6:0] ADDR_CLKOUT2  = 7'h0C;
  localparam logic [6:0] ADDR_CLKOUT3  = 7'h0E;
  localparam logic [6:0] ADDR_CLKOUT4  = 7'h10;
  localparam logic [6:0] ADDR_CLKOUT6  = 7'h12;
  localparam logic [6:0] ADDR_CLKFBOUT = 7'h14;

  function automatic logic [6:0] clkreg1_addr(input logic [2:0] sel);
    logic [6:0] a;
    case (sel)
      3'd0:    a = ADDR_CLKOUT0;
      3'd1:    a = ADDR_CLKOUT1;
      3'd2:    a = ADDR_CLKOUT2;
      3'd3:    a = ADDR_CLKOUT3;
      3'd4:    a = ADDR_CLKOUT4;
      3'd5:    a = ADDR_CLKOUT5;
      3'd6:    a = ADDR_CLKOUT6;
      default: a = ADDR_CLKFBOUT;
    endcase
    return a;
  endfunction

  // ClkReg2 always sits at the odd address following ClkReg1.
  function automatic logic [6:0] clkreg2_addr(input logic [2:0] sel);
    return clkreg1_addr(sel) | 7'h01;
  endfunction

endpackage

// File: rtl/drp_access.sv
// drp_access: one DRP transaction (issue cycle, then wait for DRDY).
// Macro: DRP_TIMEOUT_EN adds a wait-cycle counter that aborts an access
// after TIMEOUT_CYCLES cycles without DRDY.
// Ports:
//   clk_i, rst_i        DRP clock, synchronous active-high reset
//   req_i, we_i         issue request (one cycle) and write enable
//   addr_i, wdata_i     address / write data captured with req_i
//   den_o, dwe_o        registered DRP enable / write enable (issue cycle only)
//   daddr_o, di_o       registered address / write data, held after issue
//   do_i, drdy_i        DRP read data / ready from the responder
//   rdata_o             read data, valid together with done_o
//   done_o, err_o       completion / timeout strobes during the wait phase
module drp_access #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [6:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic        den_o,
  output logic        dwe_o,
  output logic [6:0]  daddr_o,
  output logic [15:0] di_o,
  input  logic [15:0] do_i,
  input  logic        drdy_i,
  output logic [15:0] rdata_o,
  output logic        done_o,
  output logic        err_o
);

  logic        den_q, dwe_q, pend_q;
  logic [6:0]  daddr_q;
  logic [15:0] di_q;
  logic        waiting;

  // The issue cycle itself is not a wait cycle, so DRDY seen with DEN is ignored.
  assign waiting = pend_q && !den_q;
  assign done_o  = waiting && drdy_i;
  assign rdata_o = do_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      pend_q  <= 1'b0;
      daddr_q <= '0;
      di_q    <= '0;
    end else begin
      den_q <= req_i;
      dwe_q <= req_i && we_i;
      if (req_i) begin
        pend_q  <= 1'b1;
        daddr_q <= addr_i;
        if (we_i) di_q <= wdata_i;
      end else if (done_o || err_o) begin
        pend_q <= 1'b0;
      end
    end
  end

`ifdef DRP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts cycles elapsed since the DEN cycle; the abort fires in the
  // last allowed wait cycle so the master reaches FIN TIMEOUT_CYCLES after DEN.
  assign err_o = waiting && !drdy_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || req_i) cnt_q <= '0;
    else if (pend_q)    cnt_q <= cnt_q + 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

  assign den_o   = den_q;
  assign dwe_o   = dwe_q;
  assign daddr_o = daddr_q;
  assign di_o    = di_q;

endmodule

// File: rtl/drp_reconf_master.sv
// drp_reconf_master: reprograms one MMCM/PLL output divider over DRP by
// read-modify-write of ClkReg1 then ClkReg2, holding PLL_RST for the sequence.
// Macro: DRP_TIMEOUT_EN enables the DRP wait timeout and the sticky ERROR flag.
// Ports:
//   DCLK, RST                    clock, synchronous active-high reset
//   START, SEL                   request strobe (IDLE only), output select
//   HIGH_TIME, LOW_TIME, PHASE_MUX, DELAY_TIME, NO_COUNT, EDGE  divider fields
//   BUSY, DONE, ERROR, PLL_RST   status / PLL reset (all registered)
//   DADDR, DEN, DWE, DI, DO, DRDY  DRP initiator interface
module drp_reconf_master
  import drp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        START,
  input  logic [2:0]  SEL,
  input  logic [5:0]  HIGH_TIME,
  input  logic [5:0]  LOW_TIME,
  input  logic [2:0]  PHASE_MUX,
  input  logic [5:0]  DELAY_TIME,
  input  logic        NO_COUNT,
  input  logic        EDGE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic        PLL_RST,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY
);

  drp_state_e  state_q, state_d;
  logic [2:0]  sel_q, phase_q, sel_eff;
  logic [5:0]  high_q, low_q, delay_q;
  logic        nocount_q, edge_q;
  logic        busy_q, done_q, pllrst_q;
  logic        start_acc, acc_req, acc_we, acc_done, acc_err;
  logic [6:0]  acc_addr;
  logic [15:0] acc_wdata, acc_rdata, merge1, merge2;

  assign start_acc = (state_q == S_IDLE) && START;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (START) state_d = S_RD1;
      S_RD1:      state_d = S_WAIT_RD1;
      S_WAIT_RD1: if (acc_err) state_d = S_FIN; else if (acc_done) state_d = S_WR1;
      S_WR1:      state_d = S_WAIT_WR1;
      S_WAIT_WR1: if (acc_err) state_d = S_FIN; else if (acc_done) state_d = S_RD2;
      S_RD2:      state_d = S_WAIT_RD2;
      S_WAIT_RD2: if (acc_err) state_d = S_FIN; else if (acc_done) state_d = S_WR2;
      S_WR2:      state_d = S_WAIT_WR2;
      S_WAIT_WR2: if (acc_err || acc_done) state_d = S_FIN;
      default:    state_d = S_IDLE;
    endcase
  end

  // Requests are decoded from the next state so DEN/DADDR/DI register on the
  // same edge the FSM enters an issue state; write data merges DO live because
  // the read completes on that very edge.
  always_comb begin
    sel_eff   = start_acc ? SEL : sel_q;
    merge1    = (acc_rdata & CLKREG1_KEEP)
              | (16'(phase_q) << PHASE_MUX_LSB)
              | (16'(high_q)  << HIGH_TIME_LSB)
              | (16'(low_q)   << LOW_TIME_LSB);
    merge2    = (acc_rdata & CLKREG2_KEEP)
              | (16'(edge_q)    << EDGE_BIT)
              | (16'(nocount_q) << NO_COUNT_BIT)
              | (16'(delay_q)   << DELAY_TIME_LSB);
    acc_req   = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = clkreg2_addr(sel_eff);
    acc_wdata = '0;
    case (state_d)
      S_RD1: begin
        acc_req  = 1'b1;
        acc_addr = clkreg1_addr(sel_eff);
      end
      S_WR1: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = clkreg1_addr(sel_eff);
        acc_wdata = merge1;
      end
      S_RD2: acc_req = 1'b1;
      S_WR2: begin
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_wdata = merge2;
      end
      default: ;
    endcase
  end

  drp_access #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_access (
    .clk_i   (DCLK),
    .rst_i   (RST),
    .req_i   (acc_req),
    .we_i    (acc_we),
    .addr_i  (acc_addr),
    .wdata_i (acc_wdata),
    .den_o   (DEN),
    .dwe_o   (DWE),
    .daddr_o (DADDR),
    .di_o    (DI),
    .do_i    (DO),
    .drdy_i  (DRDY),
    .rdata_o (acc_rdata),
    .done_o  (acc_done),
    .err_o   (acc_err)
  );

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      phase_q   <= '0;
      high_q    <= '0;
      low_q     <= '0;
      delay_q   <= '0;
      nocount_q <= 1'b0;
      edge_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pllrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        sel_q     <= SEL;
        phase_q   <= PHASE_MUX;
        high_q    <= HIGH_TIME;
        low_q     <= LOW_TIME;
        delay_q   <= DELAY_TIME;
        nocount_q <= NO_COUNT;
        edge_q    <= EDGE;
      end
      busy_q   <= (state_d != S_IDLE) && (state_d != S_FIN);
      pllrst_q <= (state_d != S_IDLE) && (state_d != S_FIN);
      done_q   <= (state_d == S_FIN);
    end
  end

`ifdef DRP_TIMEOUT_EN
  logic err_q;
  always_ff @(posedge DCLK) begin
    if (RST || start_acc) err_q <= 1'b0;
    else if (acc_err)     err_q <= 1'b1;
  end
  assign ERROR = err_q;
`else
  assign ERROR = 1'b0;
`endif

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PLL_RST = pllrst_q;

endmodule

// File: tb/tb_drp_reconf_master.sv
module tb_drp_reconf_master;

  logic        DCLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [2:0]  SEL = '0;
  logic [5:0]  HIGH_TIME = '0;
  logic [5:0]  LOW_TIME = '0;
  logic [2:0]  PHASE_MUX = '0;
  logic [5:0]  DELAY_TIME = '0;
  logic        NO_COUNT = 1'b0;
  logic        EDGE = 1'b0;
  logic        BUSY, DONE, ERROR, PLL_RST, DEN, DWE, DRDY;
  logic [6:0]  DADDR;
  logic [15:0] DI, DO;

  // responder model
  logic        resp_drdy = 1'b0;
  logic        spur = 1'b0;
  logic        no_resp = 1'b0;
  logic [15:0] resp_do = '0;
  int unsigned lat_cfg = 2;
  logic [15:0] mem [128];
  logic [6:0]  rd_addr = '0;
  int unsigned rcnt = 0;
  logic        rpend = 1'b0;

  int          den_cnt = 0, done_cnt = 0, pll_bad = 0, wr_n = 0;
  logic [6:0]  wr_addr [64];
  logic [15:0] wr_data [64];

  int errors = 0;
  int checks = 0;

  assign DRDY = resp_drdy | spur;
  assign DO   = spur ? 16'hFFFF : resp_do;

  always #5 DCLK = ~DCLK;

  drp_reconf_master #(.TIMEOUT_CYCLES(64)) dut (
    .DCLK(DCLK), .RST(RST), .START(START), .SEL(SEL),
    .HIGH_TIME(HIGH_TIME), .LOW_TIME(LOW_TIME), .PHASE_MUX(PHASE_MUX),
    .DELAY_TIME(DELAY_TIME), .NO_COUNT(NO_COUNT), .EDGE(EDGE),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .PLL_RST(PLL_RST),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY)
  );

  // Responder acts mid-cycle: DRDY set at the negedge of cycle DEN+L is
  // sampled by the DUT on the following posedge.
  always @(negedge DCLK) begin
    resp_drdy = 1'b0;
    if (DONE) done_cnt++;
    if (BUSY && !PLL_RST) pll_bad++;
    if (DEN) begin
      den_cnt++;
      rpend   = 1'b1;
      rcnt    = lat_cfg;
      rd_addr = DADDR;
      if (DWE) begin
        mem[DADDR] = DI;
        if (wr_n < 64) begin
          wr_addr[wr_n] = DADDR;
          wr_data[wr_n] = DI;
        end
        wr_n++;
      end
    end else if (rpend && !no_resp) begin
      rcnt--;
      if (rcnt == 0) begin
        resp_drdy = 1'b1;
        resp_do   = mem[rd_addr];
        rpend     = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge DCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({BUSY, DONE, ERROR, PLL_RST, DEN, DWE, DADDR, DI});
  endfunction

  // Presents a request for one cycle, then scrambles the inputs to prove capture.
  task automatic kick(input logic [2:0] s, input logic [5:0] h, input logic [5:0] l,
                      input logic [2:0] p, input logic [5:0] d, input logic nc, input logic e);
    SEL = s; HIGH_TIME = h; LOW_TIME = l; PHASE_MUX = p;
    DELAY_TIME = d; NO_COUNT = nc; EDGE = e; START = 1'b1;
    step();
    START = 1'b0;
    SEL = ~s; HIGH_TIME = ~h; LOW_TIME = ~l; PHASE_MUX = ~p;
    DELAY_TIME = ~d; NO_COUNT = ~nc; EDGE = ~e;
  endtask

  task automatic wait_done(input int start_cyc, output int lat);
    lat = start_cyc;
    while (DONE !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [6:0] a, input logic [15:0] d);
    chk(tag, 32'({wr_addr[idx], wr_data[idx]}), 32'({a, d}));
  endtask

  int lat, den0, wr0, done0, pll0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;

    // reset and idle
    RST = 1'b1;
    repeat (3) step();
    chk("reset_outputs", outs(), 32'h0);
    RST = 1'b0;
    step();
    chk("idle_outputs", outs(), 32'h0);
    spur = 1'b1; step(); spur = 1'b0; step();
    chk("idle_spurious_drdy", outs(), 32'h0);

    // SEL=0, L=2, preserve bits in read-back
    mem[8] = 16'h1000; mem[9] = 16'h8000; lat_cfg = 2;
    den0 = den_cnt; wr0 = wr_n; pll0 = pll_bad;
    kick(3'd0, 6'd6, 6'd3, 3'd3, 6'd3, 1'b1, 1'b0);
    chk("t1_rd1_issue", 32'({BUSY, PLL_RST, DEN, DWE, DADDR}), 32'({4'b1110, 7'h08}));
    step();
    chk("t1_wait_addr_hold", 32'({DEN, DADDR}), 32'({1'b0, 7'h08}));
    wait_done(2, lat);
    chk("t1_latency", 32'(lat), 32'd13);
    chk("t1_fin_flags", 32'({DONE, BUSY, PLL_RST, ERROR}), 32'b1000);
    chk("t1_write_count", 32'(wr_n - wr0), 32'd2);
    chk_wr("t1_clkreg1", wr0, 7'h08, 16'h7183);
    chk_wr("t1_clkreg2", wr0 + 1, 7'h09, 16'h8043);
    chk("t1_den_count", 32'(den_cnt - den0), 32'd4);
    chk("t1_pllrst_held", 32'(pll_bad - pll0), 32'd0);
    step();
    chk("t1_done_pulse", 32'({DONE, BUSY}), 32'd0);

    // SEL=5, zeroed registers, L=1
    lat_cfg = 1; wr0 = wr_n;
    kick(3'd5, 6'd6, 6'd3, 3'd3, 6'd3, 1'b1, 1'b0);
    wait_done(1, lat);
    chk("t2_latency", 32'(lat), 32'd9);
    chk_wr("t2_clkreg1", wr0, 7'h06, 16'h6183);
    chk_wr("t2_clkreg2", wr0 + 1, 7'h07, 16'h0043);
    step();

    // SEL=7, L=3, spurious DRDY during the RD1 issue cycle
    lat_cfg = 3; mem[20] = 16'hFFFF; mem[21] = 16'hABCD; wr0 = wr_n;
    kick(3'd7, 6'd6, 6'd3, 3'd3, 6'd3, 1'b1, 1'b0);
    spur = 1'b1; step(); spur = 1'b0;
    wait_done(2, lat);
    chk("t3_latency", 32'(lat), 32'd17);
    chk_wr("t3_clkreg1", wr0, 7'h14, 16'h7183);
    chk_wr("t3_clkreg2", wr0 + 1, 7'h15, 16'hAB43);
    step();

    // START while busy is ignored
    lat_cfg = 2; wr0 = wr_n; den0 = den_cnt; done0 = done_cnt;
    kick(3'd0, 6'd1, 6'd2, 3'd0, 6'd5, 1'b0, 1'b1);
    step(); step();
    SEL = 3'd2; HIGH_TIME = 6'd63; START = 1'b1;
    step();
    START = 1'b0;
    wait_done(4, lat);
    chk("t4_latency", 32'(lat), 32'd13);
    chk_wr("t4_clkreg1", wr0, 7'h08, 16'h1042);
    chk_wr("t4_clkreg2", wr0 + 1, 7'h09, 16'h8085);
    repeat (4) step();
    chk("t4_den_count", 32'(den_cnt - den0), 32'd4);
    chk("t4_done_count", 32'(done_cnt - done0), 32'd1);
    chk("t4_idle_after", 32'(BUSY), 32'd0);

    // RST during WAIT_WR1
    kick(3'd1, 6'd6, 6'd3, 3'd3, 6'd3, 1'b1, 1'b0);
    step(); step(); step();
    chk("t5_wr1_issue", 32'({DEN, DWE, DADDR}), 32'({2'b11, 7'h0A}));
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t5_abort_outputs", outs(), 32'h0);
    den0 = den_cnt;
    repeat (10) step();
    chk("t5_no_more_den", 32'(den_cnt - den0), 32'd0);
    chk("t5_idle_outputs", outs(), 32'h0);
    wr0 = wr_n;
    kick(3'd1, 6'd6, 6'd3, 3'd3, 6'd3, 1'b1, 1'b0);
    wait_done(1, lat);
    chk("t5_restart_latency", 32'(lat), 32'd13);
    chk_wr("t5_clkreg1", wr0, 7'h0A, 16'h6183);
    chk_wr("t5_clkreg2", wr0 + 1, 7'h0B, 16'h0043);
    step();

`ifdef DRP_TIMEOUT_EN
    // responder never answers
    no_resp = 1'b1; den0 = den_cnt;
    kick(3'd0, 6'd6, 6'd3, 3'd3, 6'd3, 1'b1, 1'b0);
    wait_done(1, lat);
    chk("t6_timeout_latency", 32'(lat), 32'd65);
    chk("t6_timeout_flags", 32'({ERROR, DONE, PLL_RST, BUSY}), 32'b1100);
    chk("t6_single_den", 32'(den_cnt - den0), 32'd1);
    step();
    chk("t6_error_sticky", 32'(ERROR), 32'd1);
    no_resp = 1'b0;
    repeat (4) step();
    kick(3'd0, 6'd6, 6'd3, 3'd3, 6'd3, 1'b1, 1'b0);
    chk("t6_error_cleared", 32'(ERROR), 32'd0);
    wait_done(1, lat);
    chk("t6_recover_latency", 32'(lat), 32'd13);
`else
    chk("t6_error_tied_low", 32'(ERROR), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
